// File: rtl/conv1_sequencer.sv
// Control sequencer for the first convolution layer: walks 7 output row groups,
// 5 kernel rows each, driving row fetch, buffer load, MAC issue and writeback.
module conv1_sequencer #(
  parameter int MAC_NUM    = 112,
  parameter int ROW_GROUPS = 7,
  parameter int KER_SIZE   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [3:0] cur_state,
  output logic [3:0] ker_row,
  output logic [3:0] ker_col,
  output logic       fm_rd_en,
  output logic [4:0] fm_rd_addr,
  output logic       buf_en,
  output logic       mac_en,
  output logic       acc_clr,
  output logic       acc_last,
  output logic [2:0] grp_idx,
  output logic       out_valid,
  input  logic       out_ready
);

  // Output rows per group follow from the lane count over the 28-column output width.
  localparam int          OUT_W        = 28;
  localparam int          ROWS_PER_GRP = MAC_NUM / OUT_W;
  localparam logic [2:0]  GRP_LAST     = 3'(ROW_GROUPS - 1);
  localparam logic [2:0]  K_LAST       = 3'(KER_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_REQ = 3'd1,
    S_LOAD_CAP = 3'd2,
    S_COMPUTE  = 3'd3,
    S_WB       = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t     r_state;
  logic [2:0] r_grp;
  logic [2:0] r_kr;
  logic [2:0] r_kc;

  logic       r_busy;
  logic       r_done;
  logic [3:0] r_cur_state;
  logic [3:0] r_ker_row;
  logic [3:0] r_ker_col;
  logic       r_fm_rd_en;
  logic [4:0] r_fm_rd_addr;
  logic       r_buf_en;
  logic       r_mac_en;
  logic       r_acc_clr;
  logic       r_acc_last;
  logic [2:0] r_grp_idx;
  logic       r_out_valid;

  state_t     w_state_nxt;
  logic [2:0] w_grp_nxt;
  logic [2:0] w_kr_nxt;
  logic [2:0] w_kc_nxt;
  logic       w_busy_nxt;
  logic       w_in_row_nxt;
  logic       w_compute_nxt;
  logic [3:0] w_cur_state_nxt;
  logic [3:0] w_ker_row_nxt;
  logic [3:0] w_ker_col_nxt;
  logic       w_fm_rd_en_nxt;
  logic [4:0] w_fm_rd_addr_nxt;
  logic       w_acc_clr_nxt;
  logic       w_acc_last_nxt;
  logic [2:0] w_grp_idx_nxt;

  // Next state and counters; outputs are decoded from the next values so that
  // registering them lines each strobe up with the state it belongs to.
  always_comb begin
    w_state_nxt = r_state;
    w_grp_nxt   = r_grp;
    w_kr_nxt    = r_kr;
    w_kc_nxt    = r_kc;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD_REQ;
          w_grp_nxt   = 3'd0;
          w_kr_nxt    = 3'd0;
          w_kc_nxt    = 3'd0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD_REQ: w_state_nxt = S_LOAD_CAP;
      S_LOAD_CAP: begin
        w_state_nxt = S_COMPUTE;
        w_kc_nxt    = 3'd0;
      end
      S_COMPUTE: begin
        if (r_kc == K_LAST) begin
          w_kc_nxt = 3'd0;
          if (r_kr < K_LAST) begin
            w_kr_nxt    = r_kr + 3'd1;
            w_state_nxt = S_LOAD_REQ;
          end else begin
            w_state_nxt = S_WB;
          end
        end else begin
          w_kc_nxt = r_kc + 3'd1;
        end
      end
      S_WB: begin
        if (out_ready) begin
          if (r_grp < GRP_LAST) begin
            w_grp_nxt   = r_grp + 3'd1;
            w_kr_nxt    = 3'd0;
            w_state_nxt = S_LOAD_REQ;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_state_nxt = S_WB;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt       = (w_state_nxt != S_IDLE);
    w_compute_nxt    = (w_state_nxt == S_COMPUTE);
    w_in_row_nxt     = (w_state_nxt == S_LOAD_REQ) || (w_state_nxt == S_LOAD_CAP) || w_compute_nxt;
    w_cur_state_nxt  = w_busy_nxt ? 4'b0001 : 4'b0000;
    w_ker_row_nxt    = w_in_row_nxt ? {1'b0, w_kr_nxt} : 4'd0;
    w_ker_col_nxt    = w_compute_nxt ? {1'b0, w_kc_nxt} : 4'd0;
    w_fm_rd_en_nxt   = (w_state_nxt == S_LOAD_REQ);
    w_fm_rd_addr_nxt = w_fm_rd_en_nxt ?
                       (5'(w_grp_nxt) * 5'(ROWS_PER_GRP) + 5'(w_kr_nxt)) : 5'd0;
    w_acc_clr_nxt    = w_compute_nxt && (w_kr_nxt == 3'd0) && (w_kc_nxt == 3'd0);
    w_acc_last_nxt   = w_compute_nxt && (w_kr_nxt == K_LAST) && (w_kc_nxt == K_LAST);
    w_grp_idx_nxt    = w_busy_nxt ? w_grp_nxt : 3'd0;
  end

  // State, counters and registered outputs; rst clears everything to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grp        <= 3'd0;
      r_kr         <= 3'd0;
      r_kc         <= 3'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cur_state  <= 4'd0;
      r_ker_row    <= 4'd0;
      r_ker_col    <= 4'd0;
      r_fm_rd_en   <= 1'b0;
      r_fm_rd_addr <= 5'd0;
      r_buf_en     <= 1'b0;
      r_mac_en     <= 1'b0;
      r_acc_clr    <= 1'b0;
      r_acc_last   <= 1'b0;
      r_grp_idx    <= 3'd0;
      r_out_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grp        <= w_grp_nxt;
      r_kr         <= w_kr_nxt;
      r_kc         <= w_kc_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= (w_state_nxt == S_DONE);
      r_cur_state  <= w_cur_state_nxt;
      r_ker_row    <= w_ker_row_nxt;
      r_ker_col    <= w_ker_col_nxt;
      r_fm_rd_en   <= w_fm_rd_en_nxt;
      r_fm_rd_addr <= w_fm_rd_addr_nxt;
      r_buf_en     <= (w_state_nxt == S_LOAD_CAP);
      r_mac_en     <= w_compute_nxt;
      r_acc_clr    <= w_acc_clr_nxt;
      r_acc_last   <= w_acc_last_nxt;
      r_grp_idx    <= w_grp_idx_nxt;
      r_out_valid  <= (w_state_nxt == S_WB);
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign cur_state  = r_cur_state;
  assign ker_row    = r_ker_row;
  assign ker_col    = r_ker_col;
  assign fm_rd_en   = r_fm_rd_en;
  assign fm_rd_addr = r_fm_rd_addr;
  assign buf_en     = r_buf_en;
  assign mac_en     = r_mac_en;
  assign acc_clr    = r_acc_clr;
  assign acc_last   = r_acc_last;
  assign grp_idx    = r_grp_idx;
  assign out_valid  = r_out_valid;

endmodule

// File: tb/tb_conv1_sequencer.sv
// Self-checking bench for conv1_sequencer: a nested-loop model of one image
// produces the expected per-cycle outputs, compared against captured DUT outputs.
module tb_conv1_sequencer;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [3:0] cs;
    logic [3:0] kr;
    logic [3:0] kc;
    logic       rd;
    logic [4:0] addr;
    logic       be;
    logic       mac;
    logic       clr;
    logic       last;
    logic [2:0] grp;
    logic       ov;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       out_ready;
  logic       busy, done, fm_rd_en, buf_en, mac_en, acc_clr, acc_last, out_valid;
  logic [3:0] cur_state, ker_row, ker_col;
  logic [4:0] fm_rd_addr;
  logic [2:0] grp_idx;

  vec_t w_obs;
  assign w_obs = {busy, done, cur_state, ker_row, ker_col, fm_rd_en, fm_rd_addr,
                  buf_en, mac_en, acc_clr, acc_last, grp_idx, out_valid};

  int   checks = 0;
  int   errors = 0;
  int   stall [7];
  vec_t exp_q [$];
  bit   care_q [$];
  bit   rdy_q [$];
  vec_t obs [$];

  conv1_sequencer #(.MAC_NUM(112), .ROW_GROUPS(7), .KER_SIZE(5)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .cur_state(cur_state), .ker_row(ker_row), .ker_col(ker_col),
    .fm_rd_en(fm_rd_en), .fm_rd_addr(fm_rd_addr), .buf_en(buf_en),
    .mac_en(mac_en), .acc_clr(acc_clr), .acc_last(acc_last),
    .grp_idx(grp_idx), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ker_row is only defined while a kernel row is being processed; grp_idx only while busy.
  function automatic vec_t msk(vec_t v, bit care_kr, bit care_grp);
    if (!care_kr) v.kr = 4'd0;
    if (!care_grp) v.grp = 3'd0;
    return v;
  endfunction

  task automatic push(vec_t e, bit care, bit rdy);
    exp_q.push_back(e);
    care_q.push_back(care);
    rdy_q.push_back(rdy);
  endtask

  // Reference model: one image as nested group/kernel-row/column loops with WB stalls.
  task automatic build_trace();
    vec_t e;
    exp_q.delete(); care_q.delete(); rdy_q.delete();
    for (int g = 0; g < 7; g++) begin
      for (int r = 0; r < 5; r++) begin
        e = '0; e.busy = 1'b1; e.cs = 4'b0001; e.grp = 3'(g); e.kr = 4'(r);
        e.rd = 1'b1; e.addr = 5'(4 * g + r);
        push(e, 1'b1, 1'($urandom));
        e.rd = 1'b0; e.addr = 5'd0; e.be = 1'b1;
        push(e, 1'b1, 1'($urandom));
        e.be = 1'b0; e.mac = 1'b1;
        for (int c = 0; c < 5; c++) begin
          e.kc = 4'(c);
          e.clr = (r == 0 && c == 0);
          e.last = (r == 4 && c == 4);
          push(e, 1'b1, 1'($urandom));
        end
      end
      for (int w = 0; w <= stall[g]; w++) begin
        e = '0; e.busy = 1'b1; e.cs = 4'b0001; e.grp = 3'(g); e.ov = 1'b1;
        push(e, 1'b0, (w == stall[g]));
      end
    end
    e = '0; e.busy = 1'b1; e.cs = 4'b0001; e.done = 1'b1; e.grp = 3'd6;
    push(e, 1'b0, 1'($urandom));
  endtask

  // Starts one image and records n cycles of DUT outputs; no checking here.
  task automatic drive_image(input int n, input int sa, input int sb, input int ri);
    obs.delete();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      out_ready = (i < rdy_q.size()) ? rdy_q[i] : 1'($urandom);
      start = (i == sa) || (i == sb);
      rst = (i == ri);
      @(negedge clk);
      obs.push_back(w_obs);
      @(posedge clk); #1;
    end
    start = 1'b0; rst = 1'b0; out_ready = 1'b0;
  endtask

  task automatic compare_trace(input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (msk(obs[i], care_q[i], 1'b1) !== msk(exp_q[i], care_q[i], 1'b1)) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", name, i, obs[i], exp_q[i]);
      end
    end
    checks++;
    if (msk(obs[exp_q.size()], 1'b0, 1'b0) !== vec_t'(0)) begin
      errors++;
      $display("FAIL %s_idle got=%h exp=0", name, obs[exp_q.size()]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start = (i == 2) ? 1'b1 : 1'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if (w_obs !== vec_t'(0)) begin
        errors++;
        $display("FAIL reset_outputs got=%h exp=0", w_obs);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (msk(w_obs, 1'b0, 1'b0) !== vec_t'(0)) begin
        errors++;
        $display("FAIL reset_start_ignored got=%h exp=0", w_obs);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_nominal();
    int n_mac, n_rd, n_be, n_clr, clr_at, done_at;
    foreach (stall[g]) stall[g] = 0;
    build_trace();
    drive_image(exp_q.size() + 2, -1, -1, -1);
    compare_trace("nominal");
    n_mac = 0; n_rd = 0; n_be = 0; n_clr = 0; clr_at = -1; done_at = -1;
    for (int i = 0; i < obs.size(); i++) begin
      n_mac += int'(obs[i].mac);
      n_rd += int'(obs[i].rd);
      n_be += int'(obs[i].be);
      if (obs[i].clr) begin n_clr++; clr_at = i; end
      if (obs[i].done) done_at = i;
    end
    checks += 4;
    if (n_mac != 175) begin errors++; $display("FAIL mac_count got=%0d exp=175", n_mac); end
    if (n_rd != 35 || n_be != 35) begin
      errors++; $display("FAIL rd_be_count got=%0d/%0d exp=35/35", n_rd, n_be);
    end
    if (n_clr != 7) begin errors++; $display("FAIL clr_count got=%0d exp=7", n_clr); end
    if (done_at != 252) begin
      errors++; $display("FAIL done_time got=t+%0d exp=t+253", done_at + 1);
    end
    checks++;
    if (!(obs[2].clr && obs[2].kc == 4'd0 && !obs[3].clr)) begin
      errors++; $display("FAIL first_clr got=%0b,%0b exp=1,0", obs[2].clr, obs[3].clr);
    end
    if (clr_at < 0) $display("note: no acc_clr seen");
  endtask

  task automatic test_random_backpressure();
    for (int k = 0; k < 3; k++) begin
      foreach (stall[g]) stall[g] = int'($urandom_range(0, 4));
      build_trace();
      drive_image(exp_q.size() + 2, -1, -1, -1);
      compare_trace("rand_bp");
    end
  endtask

  task automatic test_addr_sweep();
    logic [4:0] exp_addr [$];
    logic [4:0] got_addr [$];
    foreach (stall[g]) stall[g] = int'($urandom_range(0, 2));
    for (int g = 0; g < 7; g++)
      for (int r = 0; r < 5; r++) exp_addr.push_back(5'(4 * g + r));
    build_trace();
    drive_image(exp_q.size() + 2, -1, -1, -1);
    foreach (obs[i]) if (obs[i].rd) got_addr.push_back(obs[i].addr);
    checks++;
    if (got_addr.size() != 35) begin
      errors++; $display("FAIL addr_count got=%0d exp=35", got_addr.size());
    end else begin
      for (int i = 0; i < 35; i++) begin
        checks++;
        if (got_addr[i] !== exp_addr[i]) begin
          errors++; $display("FAIL addr_seq idx=%0d got=%0d exp=%0d", i, got_addr[i], exp_addr[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n_hold, done_at;
    foreach (stall[g]) stall[g] = 0;
    stall[2] = 10;
    build_trace();
    drive_image(exp_q.size() + 2, -1, -1, -1);
    compare_trace("bp10");
    n_hold = 0; done_at = -1;
    foreach (obs[i]) begin
      if (obs[i].ov && obs[i].grp == 3'd2) n_hold++;
      if (obs[i].done) done_at = i;
    end
    checks += 2;
    if (n_hold != 11) begin errors++; $display("FAIL bp_hold got=%0d exp=11", n_hold); end
    if (done_at != 262) begin
      errors++; $display("FAIL bp_done_time got=t+%0d exp=t+263", done_at + 1);
    end
  endtask

  task automatic test_start_ignored();
    int n_done, sz;
    foreach (stall[g]) stall[g] = 0;
    build_trace();
    sz = exp_q.size();
    drive_image(sz + 4, 49, sz - 1, -1);
    compare_trace("start_busy");
    n_done = 0;
    foreach (obs[i]) n_done += int'(obs[i].done);
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL done_count got=%0d exp=1", n_done); end
    for (int i = sz; i < sz + 4; i++) begin
      checks++;
      if (obs[i].busy !== 1'b0) begin
        errors++; $display("FAIL no_rerun cyc=%0d busy got=%0b exp=0", i, obs[i].busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    foreach (stall[g]) stall[g] = 0;
    build_trace();
    drive_image(120, 112, -1, 112);
    checks++;
    if (!(obs[112].mac && obs[112].grp == 3'd3)) begin
      errors++; $display("FAIL pre_rst_state got=%h exp=compute grp3", obs[112]);
    end
    checks++;
    if (obs[113] !== vec_t'(0)) begin
      errors++; $display("FAIL rst_mid_outputs got=%h exp=0", obs[113]);
    end
    for (int i = 114; i < 120; i++) begin
      checks++;
      if (msk(obs[i], 1'b0, 1'b0) !== vec_t'(0)) begin
        errors++; $display("FAIL rst_mid_idle cyc=%0d got=%h exp=0", i, obs[i]);
      end
    end
    build_trace();
    drive_image(exp_q.size() + 2, -1, -1, -1);
    compare_trace("restart");
  endtask

  task automatic test_acc_last();
    int n_last;
    foreach (stall[g]) stall[g] = int'($urandom_range(0, 3));
    build_trace();
    drive_image(exp_q.size() + 2, -1, -1, -1);
    n_last = 0;
    for (int i = 0; i + 1 < obs.size(); i++) begin
      if (obs[i].last) begin
        n_last++;
        checks++;
        if (!(obs[i].kr == 4'd4 && obs[i].kc == 4'd4 && obs[i + 1].ov)) begin
          errors++;
          $display("FAIL acc_last_pos cyc=%0d got kr=%0d kc=%0d next_ov=%0b exp 4,4,1",
                   i, obs[i].kr, obs[i].kc, obs[i + 1].ov);
        end
      end
    end
    checks++;
    if (n_last != 7) begin errors++; $display("FAIL acc_last_count got=%0d exp=7", n_last); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    test_reset();
    test_nominal();
    test_random_backpressure();
    test_addr_sweep();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_acc_last();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
